// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the 640x480@60 VGA path.
// Defaults describe the standard 25 MHz mode; vga_sync may override them per instance.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam logic SYNC_POL_DEF = 1'b0;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    // Inside the sync window the line sits at the asserted polarity.
    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

    // Wrap is an explicit compare against the last count, never an overflow.
    function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
        return (v == last) ? '0 : v + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bundle between vga_sync (master) and the renderer (slave).
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic   pixel_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   VGA_HS;
    logic   VGA_VS;
    logic   line_end;
    logic   frame_start;

    modport master (
        output pixel_tick,
        output pixel_x,
        output pixel_y,
        output video_on,
        output VGA_HS,
        output VGA_VS,
        output line_end,
        output frame_start
    );

    modport slave (
        input pixel_tick,
        input pixel_x,
        input pixel_y,
        input video_on,
        input VGA_HS,
        input VGA_VS,
        input line_end,
        input frame_start
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divide-by-two prescaler: one-cycle pixel_tick every other clock edge.
module pixel_tick_gen (
    input  logic clk_sys,
    input  logic rst_n,
    output logic pixel_tick
);

    logic tick_q;
    logic tick_d;

    always_comb begin
        tick_d = ~tick_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_sync.sv
// Horizontal/vertical raster counters with registered sync, blanking and wrap pulses.
// All registered outputs are decoded from next-state counts so they move with pixel_x/pixel_y.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic            CLOCK_50,
    input  logic            reset_key,
    vga_sync_if.master      vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START_C = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END_C   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START_C = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END_C   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic   pixel_tick;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   video_on_q, video_on_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   line_end_q, line_end_d;
    logic   frame_start_q, frame_start_d;
    logic   x_wrap;
    logic   y_wrap;

    pixel_tick_gen u_tick (
        .clk_sys    (CLOCK_50),
        .rst_n      (reset_key),
        .pixel_tick (pixel_tick)
    );

    always_comb begin
        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (pixel_tick) begin
            x_d = wrap_inc(x_q, H_LAST);
            if (x_wrap) begin
                y_d = wrap_inc(y_q, V_LAST);
            end
        end

        video_on_d = (x_d < H_ACT_C) && (y_d < V_ACT_C);
        hs_d       = sync_level((x_d >= HS_START_C) && (x_d <= HS_END_C), SYNC_POL);
        vs_d       = sync_level((y_d >= VS_START_C) && (y_d <= VS_END_C), SYNC_POL);

        // The prescaler toggles every edge, so the next tick level is ~pixel_tick.
        line_end_d    = ~pixel_tick && (x_d == H_LAST);
        frame_start_d = pixel_tick && x_wrap && y_wrap;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_key) begin
        if (!reset_key) begin
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b1;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_tick  = pixel_tick;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.video_on    = video_on_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.line_end    = line_end_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench: default-timing and shrunken-timing instances against an arithmetic raster model.
module tb_vga_sync;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic   tick;
        coord_t x;
        coord_t y;
        logic   von;
        logic   hs;
        logic   vs;
        logic   le;
        logic   fs;
    } obs_t;

    typedef struct packed {
        obs_t        e0;
        obs_t        e1;
        logic [31:0] n;
        logic        seg0;
    } exp_t;

    localparam int S_HA = 320, S_HF = 8, S_HS = 48, S_HB = 24;
    localparam int S_VA = 12,  S_VF = 2, S_VS = 2,  S_VB = 2;

    logic clk = 1'b0;
    logic reset_key;
    always #10 clk = ~clk;

    vga_sync_if if_def ();
    vga_sync_if if_sml ();

    vga_sync u_def (
        .CLOCK_50  (clk),
        .reset_key (reset_key),
        .vga       (if_def)
    );

    vga_sync #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) u_sml (
        .CLOCK_50  (clk),
        .reset_key (reset_key),
        .vga       (if_sml)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_clk    = 0;
    logic seg0     = 1'b1;

    int   hs_low_def  = 0;
    int   vid_off_def = 0;
    int   cap_sml     = 0;
    logic cap_done    = 1'b0;
    int   fs_cnt_sml  = 0;
    int   fs_n_sml    = -1;

    // n = clock edges since reset release; pixel index is n/2, raster position follows by div/mod.
    function automatic obs_t model(input int n, input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        obs_t o;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int p  = n / 2;
        int x  = p % ht;
        int y  = (p / ht) % vt;
        o.tick = (n % 2) == 1;
        o.x    = coord_t'(x);
        o.y    = coord_t'(y);
        o.von  = (x < ha) && (y < va);
        o.hs   = !((x >= ha + hf) && (x < ha + hf + hsw));
        o.vs   = !((y >= va + vf) && (y < va + vf + vsw));
        o.le   = o.tick && (x == ht - 1);
        o.fs   = (n > 0) && ((n % (2 * ht * vt)) == 0);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic rst_val);
        exp_t e;
        @(posedge clk);
        if (reset_key) n_clk++;
        #1;
        reset_key = rst_val;
        if (!rst_val) n_clk = 0;
        e.e0   = model(n_clk, H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
                        V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
        e.e1   = model(n_clk, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
        e.n    = n_clk;
        e.seg0 = seg0;
        sb_q.push_back(e);
    endtask

    task automatic cmp_obs(input string name, input int n, input obs_t a, input obs_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s n=%0d got tick=%0d x=%0d y=%0d von=%0d hs=%0d vs=%0d le=%0d fs=%0d expected tick=%0d x=%0d y=%0d von=%0d hs=%0d vs=%0d le=%0d fs=%0d",
                     name, n, a.tick, a.x, a.y, a.von, a.hs, a.vs, a.le, a.fs,
                     e.tick, e.x, e.y, e.von, e.hs, e.vs, e.le, e.fs);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    initial begin
        exp_t e;
        obs_t a0, a1;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                a0 = '{if_def.pixel_tick, if_def.pixel_x, if_def.pixel_y, if_def.video_on,
                       if_def.VGA_HS, if_def.VGA_VS, if_def.line_end, if_def.frame_start};
                a1 = '{if_sml.pixel_tick, if_sml.pixel_x, if_sml.pixel_y, if_sml.video_on,
                       if_sml.VGA_HS, if_sml.VGA_VS, if_sml.line_end, if_sml.frame_start};
                cmp_obs("default_raster", int'(e.n), a0, e.e0);
                cmp_obs("small_raster", int'(e.n), a1, e.e1);
                if (e.seg0 && e.n >= 1 && e.n <= 1600) begin
                    if (!a0.hs)  hs_low_def++;
                    if (!a0.von) vid_off_def++;
                end
                if (e.seg0 && !cap_done) begin
                    if (a1.y == coord_t'(S_VA)) cap_done = 1'b1;
                    else if (a1.tick && a1.von) cap_sml++;
                end
                if (e.seg0 && a1.fs) begin
                    fs_cnt_sml++;
                    fs_n_sml = int'(e.n);
                end
            end
        end
    end

    initial begin
        int hold;
        int run;
        reset_key = 1'b0;
        repeat (4) step(1'b0);
        step(1'b1);
        while (n_clk < 27100) step(1'b1);

        // Small instance now sits at x=350, y=15: inside both sync windows.
        #1;
        chk("pre_reset_x", 32'(if_sml.pixel_x), 32'd350);
        chk("pre_reset_syncs", {30'd0, if_sml.VGA_HS, if_sml.VGA_VS}, 32'd0);
        seg0 = 1'b0;
        step(1'b0);
        #1;
        chk("async_reset_syncs", {30'd0, if_sml.VGA_HS, if_sml.VGA_VS}, 32'd3);
        chk("async_reset_xy", {12'd0, if_sml.pixel_x, if_sml.pixel_y}, 32'd0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        repeat (3300) step(1'b1);

        for (int k = 0; k < 4; k++) begin
            hold = $urandom_range(1, 5);
            run  = $urandom_range(20, 4000);
            repeat (hold) step(1'b0);
            repeat (run) step(1'b1);
        end

        repeat (4) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("hs_low_clocks_line", 32'(hs_low_def), 32'd192);
        chk("video_off_clocks_line", 32'(vid_off_def), 32'd320);
        chk("capture_active_pixels", 32'(cap_sml), 32'(S_HA * S_VA));
        chk("frame_start_count", 32'(fs_cnt_sml), 32'd1);
        chk("frame_start_clock", 32'(fs_n_sml), 32'd14400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
